// File: rtl/lcd_timing_scanout.sv
// lcd_timing_scanout: raster timing generator that pops a pixel FIFO and drives a parallel RGB LCD.
// Ports:
//   clk            pixel clock, all logic on rising edge
//   areset_n       asynchronous active-low reset, synchronous release
//   fifo_q         FIFO read data, valid one clock after fifo_rdreq
//   fifo_rdreq     FIFO pop request, only ever high on active pixels
//   fifo_rdempty   FIFO empty flag
//   lcd_rgb        pixel {R,G,B}
//   lcd_de         data enable
//   lcd_hsync_n    horizontal sync, active low
//   lcd_vsync_n    vertical sync, active low
//   frame_start    one-clock pulse with the first active pixel of a frame
//   underflow      sticky flag: an active pixel found the FIFO empty
//   underflow_clr  synchronous clear of underflow (a simultaneous set wins)
module lcd_timing_scanout #(
    parameter int          H_ACTIVE      = 800,
    parameter int          H_FP          = 40,
    parameter int          H_SYNC        = 48,
    parameter int          H_BP          = 40,
    parameter int          V_ACTIVE      = 480,
    parameter int          V_FP          = 13,
    parameter int          V_SYNC        = 3,
    parameter int          V_BP          = 29,
    parameter logic [23:0] UNDERFLOW_RGB = 24'hFF00FF
) (
    input  logic        clk,
    input  logic        areset_n,
    input  logic [23:0] fifo_q,
    output logic        fifo_rdreq,
    input  logic        fifo_rdempty,
    output logic [23:0] lcd_rgb,
    output logic        lcd_de,
    output logic        lcd_hsync_n,
    output logic        lcd_vsync_n,
    output logic        frame_start,
    output logic        underflow,
    input  logic        underflow_clr
);
    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int HW = $clog2(H_TOTAL);
    localparam int VW = $clog2(V_TOTAL);
    localparam logic [HW-1:0] H_ACT  = HW'(H_ACTIVE);
    localparam logic [HW-1:0] H_S0   = HW'(H_ACTIVE + H_FP);
    localparam logic [HW-1:0] H_S1   = HW'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [HW-1:0] H_LAST = HW'(H_TOTAL - 1);
    localparam logic [VW-1:0] V_ACT  = VW'(V_ACTIVE);
    localparam logic [VW-1:0] V_S0   = VW'(V_ACTIVE + V_FP);
    localparam logic [VW-1:0] V_S1   = VW'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [VW-1:0] V_LAST = VW'(V_TOTAL - 1);

    logic [HW-1:0] h;
    logic [VW-1:0] v;
    logic active, hs, vs, fs;
    logic active1, hs1, vs1, fs1, rd1;

    always_ff @(posedge clk or negedge areset_n) begin
        if (!areset_n) begin
            h <= '0;
            v <= '0;
        end else begin
            h <= (h == H_LAST) ? '0 : h + 1'b1;
            if (h == H_LAST)
                v <= (v == V_LAST) ? '0 : v + 1'b1;
        end
    end

    always_comb begin
        active = (h < H_ACT) && (v < V_ACT);
        hs     = (h >= H_S0) && (h < H_S1);
        vs     = (v >= V_S0) && (v < V_S1);
        fs     = (h == '0) && (v == '0);
    end

    // Gated by reset so no pop is requested while the counters sit at the
    // first active pixel during reset.
    assign fifo_rdreq = active && !fifo_rdempty && areset_n;

    always_ff @(posedge clk or negedge areset_n) begin
        if (!areset_n) begin
            active1 <= 1'b0;
            hs1     <= 1'b0;
            vs1     <= 1'b0;
            fs1     <= 1'b0;
            rd1     <= 1'b0;
        end else begin
            active1 <= active;
            hs1     <= hs;
            vs1     <= vs;
            fs1     <= fs;
            rd1     <= fifo_rdreq;
        end
    end

    // A starved active slot is still consumed (filled with the marker colour)
    // so raster timing never slips.
    always_ff @(posedge clk or negedge areset_n) begin
        if (!areset_n) begin
            lcd_rgb     <= '0;
            lcd_de      <= 1'b0;
            lcd_hsync_n <= 1'b1;
            lcd_vsync_n <= 1'b1;
            frame_start <= 1'b0;
            underflow   <= 1'b0;
        end else begin
            lcd_rgb     <= rd1 ? fifo_q : (active1 ? UNDERFLOW_RGB : '0);
            lcd_de      <= active1;
            lcd_hsync_n <= !hs1;
            lcd_vsync_n <= !vs1;
            frame_start <= fs1;
            underflow   <= (active1 && !rd1) || (underflow && !underflow_clr);
        end
    end
endmodule

// File: tb/tb_lcd_timing_scanout.sv
// tb_lcd_timing_scanout: randomized check of lcd_timing_scanout against a raster-position reference model.
module tb_lcd_timing_scanout;
    localparam int HA = 16, HF = 4, HS = 5, HB = 3;
    localparam int VA = 6, VF = 2, VS = 2, VB = 3;
    localparam int HT = HA + HF + HS + HB;
    localparam int VT = VA + VF + VS + VB;
    localparam int FT = HT * VT;
    localparam logic [23:0] URGB = 24'hFF00FF;

    typedef struct {
        logic [23:0] rgb;
        logic        de;
        logic        hs_n;
        logic        vs_n;
        logic        fs;
        logic        set;
    } ent_t;

    logic        clk = 1'b0;
    logic        areset_n = 1'b0;
    logic [23:0] fifo_q = '0;
    logic        fifo_rdreq;
    logic        fifo_rdempty = 1'b0;
    logic [23:0] lcd_rgb;
    logic        lcd_de, lcd_hsync_n, lcd_vsync_n, frame_start, underflow;
    logic        underflow_clr = 1'b0;

    int   checks = 0, failures = 0;
    int   c = 0, pops = 0, rd_count = 0, rd_idx = 0;
    logic uf_exp = 1'b0, clr_last = 1'b0;
    ent_t q[$];

    lcd_timing_scanout #(
        .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
        .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
        .UNDERFLOW_RGB(URGB)
    ) dut (
        .clk(clk), .areset_n(areset_n), .fifo_q(fifo_q), .fifo_rdreq(fifo_rdreq),
        .fifo_rdempty(fifo_rdempty), .lcd_rgb(lcd_rgb), .lcd_de(lcd_de),
        .lcd_hsync_n(lcd_hsync_n), .lcd_vsync_n(lcd_vsync_n), .frame_start(frame_start),
        .underflow(underflow), .underflow_clr(underflow_clr)
    );

    always #5 clk = ~clk;

    // Non-show-ahead FIFO whose words are the running pop index.
    always @(posedge clk) begin
        if (fifo_rdreq) begin
            fifo_q <= 24'(rd_idx);
            rd_idx <= rd_idx + 1;
        end
    end

    task automatic chk1(input string tag, input logic got, input logic exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s c=%0d got=%b exp=%b", tag, c, got, exp);
        end
    endtask

    task automatic chk24(input string tag, input logic [23:0] got, input logic [23:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s c=%0d got=%h exp=%h", tag, c, got, exp);
        end
    endtask

    function automatic ent_t idle();
        ent_t e;
        e.rgb = '0; e.de = 1'b0; e.hs_n = 1'b1; e.vs_n = 1'b1; e.fs = 1'b0; e.set = 1'b0;
        return e;
    endfunction

    task automatic model_reset();
        c = 0;
        q.delete();
        q.push_back(idle());
        q.push_back(idle());
        uf_exp = 1'b0;
        clr_last = 1'b0;
    endtask

    task automatic chk_reset_outputs();
        chk24("rst_rgb", lcd_rgb, 24'h0);
        chk1("rst_de", lcd_de, 1'b0);
        chk1("rst_hsync_n", lcd_hsync_n, 1'b1);
        chk1("rst_vsync_n", lcd_vsync_n, 1'b1);
        chk1("rst_frame_start", frame_start, 1'b0);
        chk1("rst_underflow", underflow, 1'b0);
        chk1("rst_rdreq", fifo_rdreq, 1'b0);
    endtask

    // One pixel clock, entered just after a falling edge: compare outputs with
    // the prediction made two clocks ago, drive inputs, then predict this clock.
    task automatic cyc(input logic e, input logic clr);
        ent_t x;
        int p, px, py;
        logic act;
        x = q.pop_front();
        uf_exp = x.set ? 1'b1 : (clr_last ? 1'b0 : uf_exp);
        chk24("rgb", lcd_rgb, x.rgb);
        chk1("de", lcd_de, x.de);
        chk1("hsync_n", lcd_hsync_n, x.hs_n);
        chk1("vsync_n", lcd_vsync_n, x.vs_n);
        chk1("frame_start", frame_start, x.fs);
        chk1("underflow", underflow, uf_exp);
        fifo_rdempty = e;
        underflow_clr = clr;
        clr_last = clr;
        #1;
        p = c % FT;
        px = p % HT;
        py = p / HT;
        act = (px < HA) && (py < VA);
        chk1("rdreq", fifo_rdreq, act && !e);
        x.de = act;
        x.hs_n = !(px >= HA + HF && px < HA + HF + HS);
        x.vs_n = !(py >= VA + VF && py < VA + VF + VS);
        x.fs = (p == 0);
        x.set = act && e;
        x.rgb = !act ? 24'h0 : (e ? URGB : 24'(pops));
        if (act && !e) pops++;
        if (fifo_rdreq) rd_count++;
        q.push_back(x);
        c++;
    endtask

    task automatic step(input logic e, input logic clr);
        @(negedge clk);
        cyc(e, clr);
    endtask

    initial begin
        int px, py;
        repeat (3) @(negedge clk);
        #1;
        chk_reset_outputs();
        @(negedge clk);
        areset_n = 1'b1;
        model_reset();
        cyc(1'b0, 1'b0);
        // Frame 1: starved pixels x=5..7 on line 0, clear on line 1,
        // then a starve and a clear landing on the same edge on line 2.
        while (c < FT) begin
            px = (c % FT) % HT;
            py = (c % FT) / HT;
            step((py == 0 && px >= 5 && px <= 7) || (py == 2 && px == 3),
                 (py == 1 && px == 2) || (py == 2 && px == 4));
        end
        // Frame 2: FIFO never empty, count pops over exactly one frame.
        rd_count = 0;
        while (c < 2 * FT) step(1'b0, 1'b0);
        checks++;
        assert (rd_count == HA * VA) else begin
            failures++;
            $error("FAIL frame_reads got=%0d exp=%0d", rd_count, HA * VA);
        end
        // Frames 3-4: random empties and clears.
        while (c < 4 * FT)
            step($urandom_range(0, 5) == 0, $urandom_range(0, 9) == 0);
        // Mid-line reset at x=10, y=3 of frame 5.
        while (c < 4 * FT + 3 * HT + 10)
            step($urandom_range(0, 3) == 0, 1'b0);
        @(negedge clk);
        fifo_rdempty = 1'b0;
        areset_n = 1'b0;
        #1;
        chk_reset_outputs();
        repeat (2) @(negedge clk);
        #1;
        chk_reset_outputs();
        @(negedge clk);
        areset_n = 1'b1;
        model_reset();
        cyc(1'b0, 1'b0);
        while (c < FT + FT / 2)
            step($urandom_range(0, 5) == 0, $urandom_range(0, 9) == 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
